list_buffer_mq: RTL and testbench
=================================

// Module: list_buffer_mq
// PURPOSE
//  Multi-queue linked-list buffer: NUM_QUEUES logical FIFOs share one pool of DEPTH entries of WIDTH bits.
//  Parametrised successor to the fixed 40x73 ListBuffer storage. Adds a free-entry bitmap,
//  per-entry next pointers, per-queue head/tail tracking and occupancy reporting.
//  Sits between TileLink channel splitters and per-source response consumers.
// PARAMETERS
//  WIDTH       73  payload bits per entry
//  DEPTH       40  shared storage entries (>=2, need not be a power of two)
//  NUM_QUEUES  4   logical queues (>=1)
// PORTS
//  clock        in   1                   sole clock, all state rises on posedge
//  reset        in   1                   asynchronous, active-high; clears all control state
//  push_valid   in   1                   enqueue request
//  push_ready   out  1                   at least one free entry
//  push_index   in   clog2(NUM_QUEUES)   target queue
//  push_data    in   WIDTH               payload
//  valid        out  NUM_QUEUES          bit q = queue q non-empty
//  pop_valid    in   1                   dequeue head of queue pop_index this cycle
//  pop_index    in   clog2(NUM_QUEUES)   queue to read/pop
//  data         out  WIDTH               head payload of queue pop_index (combinational)
//  free_count   out  clog2(DEPTH+1)      free entries
//  pop_error    out  1                   registered pulse: pop of empty queue occurred last cycle
// BEHAVIOUR
//  - Reset: used bitmap=0, valid=0, head/tail=0, free_count=DEPTH, pop_error=0, push_ready=1. RAM not reset.
//  - Async reset asserted mid-operation drops all queued entries immediately; no partial state survives.
//  - push_ready = |~used (combinational from registered bitmap only; never depends on pop this cycle).
//  - Push fires on push_valid&&push_ready: alloc = lowest-index free entry; ram[alloc]<=push_data;
//    used[alloc]<=1; if valid[q]: next[tail[q]]<=alloc else head[q]<=alloc; tail[q]<=alloc; valid[q]<=1.
//  - data = ram[head[pop_index]] same cycle; undefined (X allowed) when !valid[pop_index].
//  - Pop fires on pop_valid&&valid[pop_index]: used[head]<=0; if head==tail valid<=0 else head<=next[head].
//  - Pop of empty queue: no state change; pop_error=1 next cycle; sim assertion fires.
//  - Freed entry is allocatable from the next cycle (not the same cycle).
//  - Simultaneous push/pop, different queues: both apply independently.
//  - Simultaneous push/pop, same queue with exactly one entry: pop removes old head; queue ends
//    with head=tail=alloc, valid stays 1 (push's head update overrides pop's clear).
//  - Same queue, >1 entry: head advances, tail/next link to alloc as normal.
//  - free_count <= free_count - push_fire + pop_fire; range 0..DEPTH, never wraps.
//  - Latency: pushed entry visible on valid/data one cycle after push fire.
//  - Per-queue order strictly FIFO; no ordering between queues.
//  - Control state (used, next, head, tail, valid, free_count) in flops; payload in RAM.
// STRUCTURE
//  - list_buffer_pkg: localparams IDX_W=clog2(DEPTH), Q_W=clog2(NUM_QUEUES), CNT_W;
//    typedefs entry_idx_t, queue_idx_t; lowest-set-bit function for allocation.
//  - Sub-module list_buffer_data_ram: DEPTH x WIDTH, 1 sync write, 1 async read port, no reset,
//    random init under RANDOMIZE_MEM_INIT; generic replacement for the fixed-size data macros.
//  - Top: bitmap allocator, next-pointer array, per-queue head/tail/valid, counter, error flag.
// TESTING
//  1 Reset, no stimulus -> push_ready=1, valid=0, free_count=40, pop_error=0.
//  2 Push 0xA,0xB,0xC to q1, pop q1 x3 -> data 0xA,0xB,0xC in order; valid[1] falls after 3rd pop; free_count back to 40.
//  3 Interleave pushes q0:1,q2:2,q0:3,q2:4; pop q2,q0,q2,q0 -> 2,1,4,3; no cross-queue leakage.
//  4 Push 40 entries (any queues) -> push_ready=0, free_count=0; 41st push_valid ignored;
//    one pop -> push_ready=1 next cycle, next push lands in the freed index.
//  5 q3 holds one entry 0x5; same cycle pop q3 + push q3 0x6 -> valid[3]=1, data=0x6, free_count unchanged.
//  6 Pop empty q0 -> pop_error=1 for one cycle, state unchanged;
//    assert reset mid-burst with 7 entries queued -> valid=0, free_count=40 before next clock edge.

Source files
------------

// File: rtl/list_buffer_pkg.sv
// Shared definitions for the multi-queue linked-list buffer: default sizing,
// index typedefs and the allocation priority encoder.
package list_buffer_pkg;

    localparam int WIDTH_DEF      = 73;
    localparam int DEPTH_DEF      = 40;
    localparam int NUM_QUEUES_DEF = 4;

    // Upper bound on DEPTH that the allocation encoder can scan.
    localparam int MAX_DEPTH = 256;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(DEPTH_DEF);
    localparam int Q_W   = idx_width(NUM_QUEUES_DEF);
    localparam int CNT_W = $clog2(DEPTH_DEF + 1);

    typedef logic [IDX_W-1:0] entry_idx_t;
    typedef logic [Q_W-1:0]   queue_idx_t;

    function automatic int lowest_set(input logic [MAX_DEPTH-1:0] vec);
        int pos;
        pos = 0;
        for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) pos = i;
        end
        return pos;
    endfunction

endpackage

// File: rtl/list_buffer_data_ram.sv
// Payload storage for the list buffer: one synchronous write port, one
// asynchronous read port, no reset on the array.
module list_buffer_data_ram #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 40,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

`ifdef RANDOMIZE_MEM_INIT
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < WIDTH; b++) begin
                mem[i][b] = 1'($urandom);
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/list_buffer_mq.sv
// Multi-queue linked-list buffer: NUM_QUEUES FIFOs share a pool of DEPTH entries,
// tracked by a used bitmap, per-entry next pointers and per-queue head/tail.
module list_buffer_mq
    import list_buffer_pkg::*;
#(
    parameter  int WIDTH      = WIDTH_DEF,
    parameter  int DEPTH      = DEPTH_DEF,
    parameter  int NUM_QUEUES = NUM_QUEUES_DEF,
    localparam int IDX_W      = idx_width(DEPTH),
    localparam int Q_W        = idx_width(NUM_QUEUES),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [Q_W-1:0]        push_index,
    input  logic [WIDTH-1:0]      push_data,
    output logic [NUM_QUEUES-1:0] valid,
    input  logic                  pop_valid,
    input  logic [Q_W-1:0]        pop_index,
    output logic [WIDTH-1:0]      data,
    output logic [CNT_W-1:0]      free_count,
    output logic                  pop_error
);

    logic [DEPTH-1:0] used;
    logic [IDX_W-1:0] next_ptr [DEPTH];
    logic [IDX_W-1:0] head     [NUM_QUEUES];
    logic [IDX_W-1:0] tail     [NUM_QUEUES];

    logic             push_q_ok;
    logic             pop_q_ok;
    logic [Q_W-1:0]   push_sel;
    logic [Q_W-1:0]   pop_sel;
    logic [IDX_W-1:0] alloc;
    logic [IDX_W-1:0] pop_head;
    logic             pop_hit;
    logic             pop_fire;
    logic             push_fire;
    logic             pop_last_same_q;

    assign push_ready = ~&used;

    always_comb begin
        push_q_ok = int'(push_index) < NUM_QUEUES;
        pop_q_ok  = int'(pop_index) < NUM_QUEUES;
        push_sel  = push_q_ok ? push_index : '0;
        pop_sel   = pop_q_ok ? pop_index : '0;
        pop_head  = head[pop_sel];
        pop_hit   = pop_q_ok && valid[pop_sel];
        pop_fire  = pop_valid && pop_hit;
        push_fire = push_valid && push_ready && push_q_ok;
        alloc     = IDX_W'(lowest_set(MAX_DEPTH'(~used)));
        // Popping the only entry of the queue being pushed: the new entry becomes the head.
        pop_last_same_q = pop_fire && (pop_sel == push_sel)
                          && (head[pop_sel] == tail[pop_sel]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            used       <= '0;
            valid      <= '0;
            free_count <= CNT_W'(DEPTH);
            pop_error  <= 1'b0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head[q] <= '0;
                tail[q] <= '0;
            end
        end else begin
            pop_error <= pop_valid && !pop_hit;

            if (pop_fire) begin
                used[pop_head] <= 1'b0;
                if (pop_head == tail[pop_sel]) valid[pop_sel] <= 1'b0;
                else                           head[pop_sel]  <= next_ptr[pop_head];
            end

            // Push is applied after pop so its head/valid update wins on the same queue.
            if (push_fire) begin
                used[alloc] <= 1'b1;
                if (!valid[push_sel] || pop_last_same_q) head[push_sel] <= alloc;
                tail[push_sel]  <= alloc;
                valid[push_sel] <= 1'b1;
            end

            case ({push_fire, pop_fire})
                2'b10:   free_count <= free_count - CNT_W'(1);
                2'b01:   free_count <= free_count + CNT_W'(1);
                default: free_count <= free_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_fire && valid[push_sel] && !pop_last_same_q) begin
            next_ptr[tail[push_sel]] <= alloc;
        end
    end

    list_buffer_data_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_data_ram (
        .clock (clock),
        .we    (push_fire),
        .waddr (alloc),
        .wdata (push_data),
        .raddr (pop_head),
        .rdata (data)
    );

`ifdef LIST_BUFFER_POP_CHECK
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(pop_valid && !pop_hit))
                else $error("list_buffer_mq: pop of empty queue %0d", pop_index);
        end
    end
`endif

endmodule

// File: tb/tb_list_buffer_mq.sv
// Directed bench for list_buffer_mq: stimulus pushes expected pop data into a
// scoreboard queue, a negedge monitor compares it whenever a pop is presented.
module tb_list_buffer_mq;

    localparam int W  = 73;
    localparam int D  = 40;
    localparam int NQ = 4;

    logic          clock;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [1:0]    push_index;
    logic [W-1:0]  push_data;
    logic [NQ-1:0] valid;
    logic          pop_valid;
    logic [1:0]    pop_index;
    logic [W-1:0]  data;
    logic [5:0]    free_count;
    logic          pop_error;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q [$];

    list_buffer_mq #(.WIDTH(W), .DEPTH(D), .NUM_QUEUES(NQ)) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_index (push_index),
        .push_data  (push_data),
        .valid      (valid),
        .pop_valid  (pop_valid),
        .pop_index  (pop_index),
        .data       (data),
        .free_count (free_count),
        .pop_error  (pop_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_push(input logic [1:0] q, input logic [W-1:0] d);
        push_valid = 1'b1;
        push_index = q;
        push_data  = d;
        step();
        push_valid = 1'b0;
    endtask

    task automatic do_pop(input logic [1:0] q, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        pop_valid = 1'b1;
        pop_index = q;
        step();
        pop_valid = 1'b0;
    endtask

    // Monitor: every accepted pop must match the oldest expected payload.
    always @(negedge clock) begin
        if (!reset && pop_valid && valid[pop_index]) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: q%0d data %0h with empty scoreboard", pop_index, data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    miscompares++;
                    $display("FAIL pop_data q%0d: got %0h expected %0h", pop_index, data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        push_valid  = 1'b0;
        push_index  = '0;
        push_data   = '0;
        pop_valid   = 1'b0;
        pop_index   = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // 1: reset state
        check("rst_push_ready", push_ready, 1);
        check("rst_valid", valid, 0);
        check("rst_free_count", free_count, 40);
        check("rst_pop_error", pop_error, 0);

        // 2: single-queue FIFO order
        do_push(2'd1, 'hA);
        do_push(2'd1, 'hB);
        do_push(2'd1, 'hC);
        check("q1_valid", valid, 4'b0010);
        check("q1_free", free_count, 37);
        do_pop(2'd1, 'hA);
        do_pop(2'd1, 'hB);
        check("q1_still_valid", valid, 4'b0010);
        do_pop(2'd1, 'hC);
        check("q1_empty", valid, 0);
        check("q1_free_back", free_count, 40);

        // 3: interleaved queues
        do_push(2'd0, 1);
        do_push(2'd2, 2);
        do_push(2'd0, 3);
        do_push(2'd2, 4);
        check("ilv_valid", valid, 4'b0101);
        do_pop(2'd2, 2);
        do_pop(2'd0, 1);
        do_pop(2'd2, 4);
        do_pop(2'd0, 3);
        check("ilv_empty", valid, 0);
        check("ilv_free", free_count, 40);

        // 4: fill the pool, refused push, refill of freed slot, drain
        for (int i = 0; i < 40; i++) do_push(2'(i % 4), W'(100 + i));
        check("full_ready", push_ready, 0);
        check("full_free", free_count, 0);
        do_push(2'd0, 999);
        check("full_ignored_free", free_count, 0);
        check("full_valid", valid, 4'hF);
        do_pop(2'd1, 101);
        check("after_pop_ready", push_ready, 1);
        check("after_pop_free", free_count, 1);
        do_push(2'd1, 555);
        check("refill_free", free_count, 0);
        check("refill_ready", push_ready, 0);
        for (int k = 0; k < 10; k++) do_pop(2'd0, W'(100 + 4 * k));
        check("drain_q0_empty", valid[0], 0);
        for (int k = 1; k < 10; k++) do_pop(2'd1, W'(101 + 4 * k));
        do_pop(2'd1, 555);
        for (int k = 0; k < 10; k++) do_pop(2'd2, W'(102 + 4 * k));
        for (int k = 0; k < 10; k++) do_pop(2'd3, W'(103 + 4 * k));
        check("drain_valid", valid, 0);
        check("drain_free", free_count, 40);

        // 5: push and pop the same single-entry queue in one cycle
        do_push(2'd3, 'h5);
        exp_q.push_back('h5);
        pop_valid  = 1'b1;
        pop_index  = 2'd3;
        push_valid = 1'b1;
        push_index = 2'd3;
        push_data  = 'h6;
        step();
        pop_valid  = 1'b0;
        push_valid = 1'b0;
        check("same_q_valid", valid, 4'b1000);
        check("same_q_free", free_count, 39);
        pop_index = 2'd3;
        #1 check("same_q_data", data[31:0], 'h6);
        do_pop(2'd3, 'h6);
        check("same_q_empty", valid, 0);

        // 6: pop of empty queue, then reset mid-burst
        pop_valid = 1'b1;
        pop_index = 2'd0;
        step();
        pop_valid = 1'b0;
        check("err_pulse", pop_error, 1);
        check("err_free", free_count, 40);
        check("err_valid", valid, 0);
        step();
        check("err_clear", pop_error, 0);
        for (int i = 0; i < 7; i++) do_push(2'(i % 4), W'(i + 1));
        check("burst_free", free_count, 33);
        push_valid = 1'b1;
        push_index = 2'd2;
        push_data  = 'h88;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", valid, 0);
        check("rst_mid_free", free_count, 40);
        check("rst_mid_ready", push_ready, 1);
        push_valid = 1'b0;
        step();
        reset = 1'b0;
        do_push(2'd2, 'h77);
        check("post_rst_valid", valid, 4'b0100);
        do_pop(2'd2, 'h77);
        step();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
